// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI field constants and the posted-store entry type
package axi_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: store queue with wrap-around pointers and occupancy count.
// Ports: aclk/aresetn (sync, active low); push/din enqueue; pop dequeues head;
// full, count, rd_ptr, head (oldest entry) and ents (all slots) for the probe.
module wb_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        push,
  input  logic                        pop,
  input  wb_entry_t                   din,
  output logic                        full,
  output logic [CW-1:0]               count,
  output logic [PW-1:0]               rd_ptr,
  output wb_entry_t                   head,
  output wb_entry_t [DEPTH-1:0]       ents
);
  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] wr_ptr;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign full = count == CW'(DEPTH);
  assign head = mem[rd_ptr];
  assign ents = mem;
endmodule

// File: rtl/axi_write_buffer.sv
// axi_write_buffer: posted-store buffer draining CPU stores to AXI3 AW/W/B one at a time.
// Ports: aclk/aresetn (sync, active low); req_* store request in; chk_addr load probe
// with chk_hit (stall) and fwd_valid/fwd_data (forward); empty, sticky wr_err;
// aw*/w*/b* AXI3 write channels with fixed single-beat INCR fields.
// Build option: define WB_FWD_EN to forward full-word pending stores to probing loads.
module axi_write_buffer
  import axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_size,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic        empty,
  output logic        wr_err,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
  state_t state, state_n;
  logic aw_pend, aw_pend_n, w_pend, w_pend_n;
  logic push, pop, full, hit;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [31:0] sel_data;
  logic [3:0] sel_strb;
  wb_entry_t din, head;
  wb_entry_t [DEPTH-1:0] ents;
  assign din = '{addr: req_addr, data: req_data, strb: req_strb, size: req_size};
  assign req_ready = aresetn && !full;
  assign push = req_valid && req_ready;
  assign pop = (state == RESP) && bvalid;
  assign empty = count == '0;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(push), .pop(pop), .din(din),
    .full(full), .count(count), .rd_ptr(rd_ptr), .head(head), .ents(ents)
  );
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_n;
      aw_pend <= aw_pend_n;
      w_pend  <= w_pend_n;
      if (pop && bresp != RESP_OKAY) wr_err <= 1'b1;
    end
  end
  // A push into an empty buffer launches at the same edge it is written, so
  // awvalid appears one cycle after the request.
  always_comb begin
    state_n   = state;
    aw_pend_n = aw_pend;
    w_pend_n  = w_pend;
    case (state)
      IDLE: if (!empty || push) begin
        state_n   = SEND;
        aw_pend_n = 1'b1;
        w_pend_n  = 1'b1;
      end
      SEND: begin
        aw_pend_n = aw_pend && !awready;
        w_pend_n  = w_pend && !wready;
        if (!aw_pend_n && !w_pend_n) state_n = RESP;
      end
      RESP: if (bvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign awvalid = aw_pend;
  assign wvalid  = w_pend;
  assign bready  = state == RESP;
  assign awid    = AXI_ID;
  assign awaddr  = head.addr;
  assign awlen   = 4'd0;
  assign awsize  = head.size;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID;
  assign wdata   = head.data;
  assign wstrb   = head.strb;
  assign wlast   = 1'b1;
  // Walk oldest to youngest so the youngest matching store is the one kept.
  always_comb begin
    hit      = 1'b0;
    sel_data = '0;
    sel_strb = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && ents[rd_ptr + PW'(k)].addr[31:2] == chk_addr[31:2]) begin
        hit      = 1'b1;
        sel_data = ents[rd_ptr + PW'(k)].data;
        sel_strb = ents[rd_ptr + PW'(k)].strb;
      end
    end
  end
`ifdef WB_FWD_EN
  assign fwd_valid = hit && sel_strb == 4'hF;
  assign fwd_data  = fwd_valid ? sel_data : '0;
  assign chk_hit   = hit && !fwd_valid;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
  assign chk_hit   = hit;
`endif
  logic unused;
  assign unused = ^{chk_addr[1:0], bid, ents, sel_data, sel_strb};
endmodule

// File: tb/tb_axi_write_buffer.sv
// tb_axi_write_buffer: directed tables, corner sequences and random stores against a queue model
module tb_axi_write_buffer;
  import axi_pkg::*;
  localparam int DEPTH = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic aclk = 1'b0, aresetn = 1'b0;
  logic req_valid, req_ready, chk_hit, fwd_valid, empty, wr_err;
  logic [31:0] req_addr, req_data, chk_addr, fwd_data, awaddr, wdata;
  logic [3:0] req_strb, awid, awlen, awcache, wid, wstrb, bid;
  logic [2:0] req_size, awsize, awprot;
  logic [1:0] awburst, awlock, bresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  always #5 aclk = ~aclk;
  axi_write_buffer #(.DEPTH(DEPTH), .AXI_ID(4'h1)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .req_size(req_size),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .empty(empty), .wr_err(wr_err), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );
  typedef struct {
    logic [31:0] chk;
    logic        hit;
    logic        fv;
    logic [31:0] fd;
  } row_t;
  row_t rows[6];
  wb_entry_t exp_q[$];
  wb_entry_t push_ent;
  bit push_pend, err_m, hold, b_fire, aw_got, w_got;
  int aw_lat, w_lat, b_lat, aw_wait, w_wait, b_wait, nwr, err_idx, n_chk, n_err;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask
  function automatic bit exp_ready();
    return aresetn && exp_q.size() < DEPTH;
  endfunction
  // Youngest pending store to the same word decides: forward if full-word and enabled, else stall.
  function automatic void probe(input logic [31:0] a, output logic h, output logic fv, output logic [31:0] fd);
    bit m = 0;
    wb_entry_t e = '0;
    foreach (exp_q[i]) if (exp_q[i].addr[31:2] == a[31:2]) begin
      m = 1;
      e = exp_q[i];
    end
    fv = m && FWD && e.strb == 4'hF;
    fd = fv ? e.data : 32'h0;
    h  = m && !fv;
  endfunction
  // One negedge: retire events of the previous posedge, then run the AXI slave model.
  task automatic tick();
    @(negedge aclk);
    if (!aresetn) begin
      exp_q.delete();
      push_pend = 0; err_m = 0; b_fire = 0; aw_got = 0; w_got = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      return;
    end
    if (push_pend) begin
      exp_q.push_back(push_ent);
      push_pend = 0;
    end
    if (b_fire) begin
      b_fire = 0;
      bvalid = 0;
      err_m |= bresp != 2'b00;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      nwr++;
    end
    if (awready) begin
      awready = 0;
      aw_got = 1;
      chk("aw_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("awaddr", awaddr, exp_q[0].addr);
        chk("awsize", awsize, exp_q[0].size);
      end
    end else if (awvalid && !aw_got && !hold) begin
      if (aw_wait >= aw_lat) awready = 1; else aw_wait++;
    end
    if (wready) begin
      wready = 0;
      w_got = 1;
      chk("w_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("wdata", wdata, exp_q[0].data);
        chk("wstrb", wstrb, exp_q[0].strb);
      end
    end else if (wvalid && !w_got) begin
      if (w_wait >= w_lat) wready = 1; else w_wait++;
    end
    if (!bvalid && aw_got && w_got) begin
      if (b_wait >= b_lat) begin
        bvalid = 1;
        bresp = (nwr == err_idx) ? 2'b10 : 2'b00;
      end else b_wait++;
    end
    chk("bready_order", bready && !(aw_got && w_got), 0);
    if (bvalid && bready) b_fire = 1;
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] c);
    logic h, fv;
    logic [31:0] fd;
    tick();
    req_valid = v;
    req_addr = a;
    req_data = d;
    req_strb = s;
    req_size = (s == 4'hF) ? SIZE_W : (s == 4'h3 || s == 4'hC) ? SIZE_H : SIZE_B;
    chk_addr = c;
    #1;
    probe(c, h, fv, fd);
    chk("req_ready", req_ready, exp_ready());
    chk("empty", empty, exp_q.size() == 0);
    chk("chk_hit", chk_hit, h);
    chk("fwd_valid", fwd_valid, fv);
    chk("fwd_data", fwd_data, fd);
    chk("wr_err", wr_err, err_m);
    push_pend = v && exp_ready();
    push_ent = '{addr: a, data: d, strb: s, size: req_size};
  endtask
  task automatic idle();
    step(0, 32'h0, 32'h0, 4'h0, 32'hFFFF_FFF0);
  endtask
  task automatic drain(input int max);
    int n = 0;
    do begin
      idle();
      n++;
    end while ((exp_q.size() != 0 || push_pend) && n < max);
    chk("drain_done", exp_q.size() == 0 && !push_pend, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, base;
    logic [31:0] a;
    logic [3:0] s;
    req_valid = 0; req_addr = 0; req_data = 0; req_strb = 0; req_size = 0; chk_addr = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 4'h1;
    aw_lat = 0; w_lat = 0; b_lat = 0; err_idx = -1; hold = 0;
    rows[0] = '{32'h0000_0100, !FWD, FWD, FWD ? 32'h1122_3344 : 32'h0};
    rows[1] = '{32'h0000_0103, !FWD, FWD, FWD ? 32'h1122_3344 : 32'h0};
    rows[2] = '{32'h0000_0204, 1'b1, 1'b0, 32'h0};
    rows[3] = '{32'h0000_0300, 1'b1, 1'b0, 32'h0};
    rows[4] = '{32'h0000_0104, 1'b0, 1'b0, 32'h0};
    rows[5] = '{32'h0000_0400, 1'b0, 1'b0, 32'h0};
    idle();
    idle();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_req_ready", req_ready, 0);
    aresetn = 1;
    idle();
    chk("post_rst_ready", req_ready, 1);
    step(1, 32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    idle();
    chk("lat_awvalid", awvalid, 1);
    chk("lat_wvalid", wvalid, 1);
    chk("s_awaddr", awaddr, 32'h1FC0_0010);
    chk("s_wdata", wdata, 32'hDEAD_BEEF);
    chk("s_awsize", awsize, 3'd2);
    chk("s_fixed", {awid, wid, awlen, awburst, awlock, awcache, awprot, wlast},
        {4'h1, 4'h1, 4'h0, 2'b01, 2'b00, 4'h0, 3'h0, 1'b1});
    drain(20);
    hold = 1;
    step(1, 32'h0000_0100, 32'h1122_3344, 4'hF, 32'h0);
    step(1, 32'h0000_0204, 32'h0000_00AA, 4'h1, 32'h0);
    step(1, 32'h0000_0300, 32'h5566_7788, 4'hF, 32'h0);
    step(1, 32'h0000_0302, 32'h99AA_BBCC, 4'hC, 32'h0);
    foreach (rows[i]) begin
      step(1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, rows[i].chk);
      chk($sformatf("row%0d_ready", i), req_ready, 0);
      chk($sformatf("row%0d_hit", i), chk_hit, rows[i].hit);
      chk($sformatf("row%0d_fv", i), fwd_valid, rows[i].fv);
      chk($sformatf("row%0d_fd", i), fwd_data, rows[i].fd);
    end
    hold = 0;
    n = 0;
    do begin
      step(1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h0);
      n++;
    end while (!push_pend && n < 30);
    chk("fifth_accepted", push_pend, 1);
    drain(60);
    aw_lat = 3;
    w_lat = 0;
    base = nwr;
    step(1, 32'h0000_0500, 32'h0BAD_F00D, 4'hF, 32'h0);
    step(1, 32'h0000_0504, 32'h1234_5678, 4'h3, 32'h0);
    n = 0;
    do begin
      idle();
      if (w_got && !aw_got) begin
        chk("skew_wvalid", wvalid, 0);
        chk("skew_awvalid", awvalid, 1);
      end
      n++;
    end while (exp_q.size() != 0 && n < 60);
    chk("skew_drained", exp_q.size(), 0);
    chk("b_per_entry", nwr - base, 2);
    aw_lat = 0;
    err_idx = nwr + 1;
    step(1, 32'h0000_0600, 32'h0000_0001, 4'hF, 32'h0);
    step(1, 32'h0000_0604, 32'h0000_0002, 4'hF, 32'h0);
    step(1, 32'h0000_0608, 32'h0000_0003, 4'hF, 32'h0);
    drain(60);
    chk("wr_err_set", wr_err, 1);
    step(1, 32'h0000_060C, 32'h0000_0004, 4'hF, 32'h0);
    drain(30);
    chk("wr_err_sticky", wr_err, 1);
    b_lat = 20;
    step(1, 32'h0000_0700, 32'h7, 4'hF, 32'h0);
    step(1, 32'h0000_0704, 32'h8, 4'hF, 32'h0);
    step(1, 32'h0000_0708, 32'h9, 4'hF, 32'h0);
    n = 0;
    do begin
      idle();
      n++;
    end while (!bready && n < 20);
    chk("reach_resp", bready, 1);
    aresetn = 0;
    idle();
    chk("rst2_awvalid", awvalid, 0);
    chk("rst2_wvalid", wvalid, 0);
    chk("rst2_bready", bready, 0);
    chk("rst2_empty", empty, 1);
    chk("rst2_req_ready", req_ready, 0);
    chk("rst2_wr_err", wr_err, 0);
    idle();
    chk("rst2_hold_ready", req_ready, 0);
    aresetn = 1;
    b_lat = 0;
    idle();
    chk("rst2_release_ready", req_ready, 1);
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        aw_lat = $urandom_range(0, 2);
        w_lat = $urandom_range(0, 2);
        b_lat = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 40) == 0) err_idx = nwr + 1;
      a = 32'h0000_1000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      s = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(1, 15));
      step(1'($urandom_range(0, 1)), a, $urandom,  s,
           32'h0000_1000 | ($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
    end
    drain(100);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
